sie_rx_packet_parser: RTL and testbench

Receive-side packet parser of the SIE. Consumes the NRZI-decoded, bit-unstuffed serial stream from the line receiver and turns it into structured USB packet fields:
- hunts for SYNC;
- decodes and validates the PID;
- extracts token fields or streams data bytes, holding back the trailing CRC16;
- checks CRC5/CRC16 and packet length, then reports per-packet status at EOP.

It is the receiving counterpart of the packet framing defined in `sie_defs_pkg` and feeds the device transaction FSM.

---
 rtl/sie_defs_pkg.sv | 19 +
 rtl/sie_crc_serial.sv | 21 ++
 rtl/sie_rx_packet_parser.sv | 141 ++++++++++++++
 tb/tb_sie_rx_packet_parser.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sie_defs_pkg.sv
// sie_defs_pkg: shared USB SIE definitions - PID codes, SYNC pattern, CRC constants, PID check helper.
package sie_defs_pkg;
    typedef enum logic [3:0] {
        PID_RSVD  = 4'b0000, PID_OUT   = 4'b0001, PID_ACK   = 4'b0010, PID_DATA0 = 4'b0011,
        PID_PING  = 4'b0100, PID_SOF   = 4'b0101, PID_NYET  = 4'b0110, PID_DATA2 = 4'b0111,
        PID_SPLIT = 4'b1000, PID_IN    = 4'b1001, PID_NAK   = 4'b1010, PID_DATA1 = 4'b1011,
        PID_PRE   = 4'b1100, PID_SETUP = 4'b1101, PID_STALL = 4'b1110, PID_MDATA = 4'b1111
    } PID_Types;
    localparam logic [7:0]  SYNC_VALUE     = 8'h80;
    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_INIT      = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    function automatic logic pid_check(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction
endpackage

// File: rtl/sie_crc_serial.sv
// sie_crc_serial: LSb-first serial CRC; o_match reflects the register after this cycle's bit.
module sie_crc_serial #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] POLY     = '0,
    parameter logic [WIDTH-1:0] INIT     = '1,
    parameter logic [WIDTH-1:0] RESIDUAL = '0
) (
    input  logic clk48,
    input  logic rst_n,
    input  logic i_init,
    input  logic i_en,
    input  logic i_bit,
    output logic o_match
);
    logic [WIDTH-1:0] r_crc, w_next;
    assign w_next  = i_en ? ({r_crc[WIDTH-2:0], 1'b0} ^ ((i_bit ^ r_crc[WIDTH-1]) ? POLY : '0)) : r_crc;
    assign o_match = w_next == RESIDUAL;
    always_ff @(posedge clk48 or negedge rst_n)
        if (!rst_n) r_crc <= INIT;
        else        r_crc <= i_init ? INIT : w_next;
endmodule

// File: rtl/sie_rx_packet_parser.sv
// sie_rx_packet_parser: SIE receive parser - SYNC hunt, PID decode, token/data extraction, length/CRC status.
// Build option SIE_RX_CRC_CHECK_EN instantiates the CRC5/CRC16 checkers; otherwise errCrc stays 0.
module sie_rx_packet_parser
    import sie_defs_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic        clk48,
    input  logic        rst_n,
    input  logic        rxBitValid,
    input  logic        rxBit,
    input  logic        rxEop,
    output logic        pktStart,
    output logic        pidValid,
    output logic [3:0]  pid,
    output logic        dataByteValid,
    output logic [7:0]  dataByte,
    output logic        tokenValid,
    output logic [10:0] tokenData,
    output logic        pktDone,
    output logic        pktOk,
    output logic        errPid,
    output logic        errCrc,
    output logic        errLen
);
    localparam int BW = $clog2(MAX_DATA_BYTES + 3);
    typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HANDSHAKE, DRAIN} state_t;
    state_t        r_state, w_bstate, w_state_n;
    logic [7:0]    r_sr, w_sr, r_hold0, r_hold1, r_dbyte;
    logic [4:0]    r_cnt, w_cnt;
    logic [BW-1:0] r_bytes, w_bytes;
    logic [10:0]   r_tok;
    logic [3:0]    r_pid;
    logic          r_pktStart, r_pidValid, r_dvalid, r_tokValid, r_pktDone;
    logic          r_pktOk, r_errPid, r_errCrc, r_errLen;
    logic          w_sync, w_pid_end, w_pid_ok, w_tok_bit, w_tok_over, w_dat_bit, w_byte_end;
    logic          w_dat_over, w_hs_over, w_eop, w_emit, w_len_bad, w_crc_bad, w_err_pid, w_err_len;
    logic          w_crc5_ok, w_crc16_ok;

    assign w_sr       = {rxBit, r_sr[7:1]};
    assign w_sync     = r_state == IDLE && rxBitValid && w_sr == SYNC_VALUE;
    assign w_pid_end  = r_state == PID && rxBitValid && r_cnt == 5'd7;
    assign w_pid_ok   = pid_check(w_sr) && w_sr[1:0] != 2'b00 && w_sr[3:0] != PID_DATA2 && w_sr[3:0] != PID_MDATA;
    assign w_tok_bit  = r_state == TOKEN && rxBitValid;
    assign w_tok_over = w_tok_bit && r_cnt == 5'd16;
    assign w_dat_bit  = r_state == DATA && rxBitValid;
    assign w_byte_end = w_dat_bit && r_cnt[2:0] == 3'd7;
    assign w_dat_over = w_byte_end && r_bytes == BW'(MAX_DATA_BYTES + 2);
    assign w_hs_over  = r_state == HANDSHAKE && rxBitValid;
    assign w_eop      = rxEop && r_state != IDLE;

`ifdef SIE_RX_CRC_CHECK_EN
    sie_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT), .RESIDUAL(CRC5_RESIDUAL)) u_crc5 (
        .clk48(clk48), .rst_n(rst_n), .i_init(w_sync), .i_en(w_tok_bit && !w_tok_over),
        .i_bit(rxBit), .o_match(w_crc5_ok)
    );
    sie_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT), .RESIDUAL(CRC16_RESIDUAL)) u_crc16 (
        .clk48(clk48), .rst_n(rst_n), .i_init(w_sync), .i_en(w_dat_bit && !w_dat_over),
        .i_bit(rxBit), .o_match(w_crc16_ok)
    );
`else
    assign w_crc5_ok  = 1'b1;
    assign w_crc16_ok = 1'b1;
`endif

    always_ff @(posedge clk48 or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_n;

    // w_bstate is the state after consuming this cycle's bit; EOP is judged against it
    always_comb begin
        w_bstate  = w_sync ? PID :
                    w_pid_end ? (!w_pid_ok ? DRAIN : w_sr[1:0] == 2'b01 ? TOKEN : w_sr[1:0] == 2'b11 ? DATA : HANDSHAKE) :
                    (w_tok_over || w_dat_over || w_hs_over) ? DRAIN : r_state;
        w_state_n = w_eop ? IDLE : w_bstate;
    end

    always_comb begin
        w_cnt     = (w_bstate != r_state) ? 5'd0 : r_cnt + 5'(rxBitValid);
        w_bytes   = (w_bstate != DATA) ? '0 : r_bytes + BW'(w_byte_end);
        w_emit    = w_byte_end && !w_dat_over && r_bytes >= BW'(2);
        w_len_bad = w_bstate == PID || (w_bstate == TOKEN && w_cnt != 5'd16) ||
                    (w_bstate == DATA && (w_cnt[2:0] != 3'd0 || w_bytes < BW'(2)));
        w_crc_bad = (w_bstate == TOKEN && !w_crc5_ok) || (w_bstate == DATA && !w_crc16_ok);
        w_err_pid = r_errPid || (w_pid_end && !w_pid_ok);
        w_err_len = r_errLen || w_tok_over || w_dat_over || w_hs_over || (w_eop && w_len_bad);
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_bytes    <= '0;
            r_hold0    <= '0;
            r_hold1    <= '0;
            r_dbyte    <= '0;
            r_tok      <= '0;
            r_pid      <= '0;
            r_pktStart <= 1'b0;
            r_pidValid <= 1'b0;
            r_dvalid   <= 1'b0;
            r_tokValid <= 1'b0;
            r_pktDone  <= 1'b0;
            r_pktOk    <= 1'b0;
            r_errPid   <= 1'b0;
            r_errCrc   <= 1'b0;
            r_errLen   <= 1'b0;
        end else begin
            r_sr       <= (w_sync || w_eop) ? '0 : rxBitValid ? w_sr : r_sr;
            r_cnt      <= w_cnt;
            r_bytes    <= w_bytes;
            r_hold0    <= (w_byte_end && !w_dat_over) ? w_sr : r_hold0;
            r_hold1    <= (w_byte_end && !w_dat_over) ? r_hold0 : r_hold1;
            r_dbyte    <= w_emit ? r_hold1 : r_dbyte;
            r_dvalid   <= w_emit;
            r_tok      <= (w_tok_bit && r_cnt < 5'd11) ? {rxBit, r_tok[10:1]} : r_tok;
            r_pid      <= (w_pid_end && w_pid_ok) ? w_sr[3:0] : r_pid;
            r_pktStart <= w_sync;
            r_pidValid <= w_pid_end && w_pid_ok;
            r_pktDone  <= w_eop;
            r_tokValid <= w_eop && w_bstate == TOKEN && !(w_err_pid || w_err_len || w_crc_bad);
            r_errPid   <= w_sync ? 1'b0 : w_err_pid;
            r_errLen   <= w_sync ? 1'b0 : w_err_len;
            r_errCrc   <= w_sync ? 1'b0 : w_eop ? w_crc_bad : r_errCrc;
            r_pktOk    <= w_sync ? 1'b0 : w_eop ? !(w_err_pid || w_err_len || w_crc_bad) : r_pktOk;
        end
    end

    assign pktStart      = r_pktStart;
    assign pidValid      = r_pidValid;
    assign pid           = r_pid;
    assign dataByteValid = r_dvalid;
    assign dataByte      = r_dbyte;
    assign tokenValid    = r_tokValid;
    assign tokenData     = r_tok;
    assign pktDone       = r_pktDone;
    assign pktOk         = r_pktOk;
    assign errPid        = r_errPid;
    assign errCrc        = r_errCrc;
    assign errLen        = r_errLen;
endmodule

// File: tb/tb_sie_rx_packet_parser.sv
// tb_sie_rx_packet_parser: directed scoreboard bench for the SIE receive packet parser.
`timescale 1ns/1ps
module tb_sie_rx_packet_parser;
    logic        clk48 = 1'b0, rst_n = 1'b0, rxBitValid = 1'b0, rxBit = 1'b0, rxEop = 1'b0;
    logic        pktStart, pidValid, dataByteValid, tokenValid, pktDone, pktOk, errPid, errCrc, errLen;
    logic [3:0]  pid;
    logic [7:0]  dataByte;
    logic [10:0] tokenData;

    typedef struct packed {
        logic ok, ep, ec, el, tv, skip_ec;
        logic [10:0] td;
    } done_t;

    done_t      q_done[$];
    logic [7:0] q_byte[$];
    logic [3:0] q_pid[$];
    int         q_start[$];
    logic [7:0] tx[$];
    done_t      d_m;
    int         checks = 0, errors = 0;

    always #10 clk48 = ~clk48;

    sie_rx_packet_parser #(.MAX_DATA_BYTES(64)) dut (
        .clk48(clk48), .rst_n(rst_n), .rxBitValid(rxBitValid), .rxBit(rxBit), .rxEop(rxEop),
        .pktStart(pktStart), .pidValid(pidValid), .pid(pid), .dataByteValid(dataByteValid),
        .dataByte(dataByte), .tokenValid(tokenValid), .tokenData(tokenData), .pktDone(pktDone),
        .pktOk(pktOk), .errPid(errPid), .errCrc(errCrc), .errLen(errLen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic done_t mk(input logic ok, ep, ec, el, tv, input logic [10:0] td, input logic sk);
        done_t d;
        d.ok = ok; d.ep = ep; d.ec = ec; d.el = el; d.tv = tv; d.td = td; d.skip_ec = sk;
        return d;
    endfunction

    // CRC16 field bytes (LSb-first on the wire) for tx[first .. first+n-1]
    function automatic logic [15:0] crc16_field(input int first, input int n);
        logic [15:0] c, t;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = first; k < first + n; k++) begin
            b = tx[k];
            for (int j = 0; j < 8; j++) c = {c[14:0], 1'b0} ^ ((b[j] ^ c[15]) ? 16'h8005 : 16'h0000);
        end
        for (int i = 0; i < 16; i++) t[i] = ~c[15-i];
        return t;
    endfunction

    task automatic tick;
        @(posedge clk48);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic e);
        rxBitValid = 1'b1; rxBit = b; rxEop = e;
        tick;
        rxBitValid = 1'b0; rxBit = 1'b0; rxEop = 1'b0;
        if ($urandom_range(0, 3) == 0) tick;
    endtask

    task automatic send_pkt(input int nbits, input bit eop_last, input bit do_eop, input done_t d);
        logic [7:0] b;
        q_start.push_back(1);
        for (int i = 0; i < 8; i++) send_bit(i == 7, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            b = tx[i / 8];
            if (eop_last && i == nbits - 1) q_done.push_back(d);
            send_bit(b[i % 8], eop_last && i == nbits - 1);
        end
        if (do_eop && !eop_last) begin
            q_done.push_back(d);
            rxEop = 1'b1;
            tick;
            rxEop = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((q_done.size() + q_byte.size() + q_pid.size() + q_start.size()) != 0 && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_done_pending"}, q_done.size(), 0);
        chk({tag, "_bytes_pending"}, q_byte.size(), 0);
        chk({tag, "_pid_pending"}, q_pid.size(), 0);
        chk({tag, "_start_pending"}, q_start.size(), 0);
    endtask

    task automatic push_payload(input int first, input int n);
        for (int k = first; k < first + n; k++) q_byte.push_back(tx[k]);
    endtask

    always @(negedge clk48) if (rst_n) begin
        if (pktStart) begin
            chk("pktStart_expected", q_start.size() > 0, 1);
            if (q_start.size() > 0) void'(q_start.pop_front());
        end
        if (pidValid) begin
            chk("pidValid_expected", q_pid.size() > 0, 1);
            if (q_pid.size() > 0) chk("pid", pid, q_pid.pop_front());
        end
        if (dataByteValid) begin
            chk("dataByteValid_expected", q_byte.size() > 0, 1);
            if (q_byte.size() > 0) chk("dataByte", dataByte, q_byte.pop_front());
        end
        if (tokenValid) chk("tokenValid_with_pktDone", pktDone, 1);
        if (pktDone) begin
            chk("pktDone_expected", q_done.size() > 0, 1);
            if (q_done.size() > 0) begin
                d_m = q_done.pop_front();
                chk("pktOk", pktOk, d_m.ok);
                chk("errPid", errPid, d_m.ep);
                chk("errLen", errLen, d_m.el);
                chk("tokenValid", tokenValid, d_m.tv);
                if (!d_m.skip_ec) chk("errCrc", errCrc, d_m.ec);
                if (d_m.tv) chk("tokenData", tokenData, d_m.td);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        chk("reset_outputs", {pktStart, pidValid, pid, dataByteValid, dataByte, tokenValid, tokenData,
                              pktDone, pktOk, errPid, errCrc, errLen}, 32'h0);
        rst_n = 1'b1;
        repeat (2) tick;
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);

        tx = '{8'hD2};
        q_pid.push_back(4'h2);
        send_pkt(8, 0, 1, mk(1, 0, 0, 0, 0, 11'h0, 0));
        wait_idle("ack");
        repeat (4) tick;
        chk("ack_ok_held", pktOk, 1);

        tx = '{8'h2D, 8'h00, 8'h10};
        q_pid.push_back(4'hD);
        send_pkt(24, 0, 1, mk(1, 0, 0, 0, 1, 11'h000, 0));
        wait_idle("setup");

        tx = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        q_pid.push_back(4'h3);
        push_payload(1, 8);
        send_pkt(88, 0, 1, mk(1, 0, 0, 0, 0, 11'h0, 0));
        wait_idle("data0");

        tx[1] = 8'h81;
        q_pid.push_back(4'h3);
        push_payload(1, 8);
`ifdef SIE_RX_CRC_CHECK_EN
        send_pkt(88, 0, 1, mk(0, 0, 1, 0, 0, 11'h0, 0));
`else
        send_pkt(88, 0, 1, mk(1, 0, 0, 0, 0, 11'h0, 0));
`endif
        wait_idle("data0_flip");

        tx = '{8'hD3, 8'h00, 8'h00};
        send_pkt(24, 0, 1, mk(0, 1, 0, 0, 0, 11'h0, 0));
        wait_idle("badpid");
        repeat (4) tick;
        chk("errPid_held", errPid, 1);
        chk("badpid_ok_held", pktOk, 0);

        tx = '{8'h4B, 8'h00, 8'h00};
        q_pid.push_back(4'hB);
        send_pkt(24, 0, 1, mk(1, 0, 0, 0, 0, 11'h0, 0));
        wait_idle("data1_empty");

        tx = '{8'hC3, 8'h80, 8'h06};
        q_pid.push_back(4'h3);
        send_pkt(20, 0, 1, mk(0, 0, 0, 1, 0, 11'h0, 1));
        wait_idle("data_12bits");

        tx = '{8'h69, 8'h00, 8'h10, 8'h00};
        q_pid.push_back(4'h9);
        send_pkt(25, 0, 1, mk(0, 0, 0, 1, 0, 11'h0, 0));
        wait_idle("token_17bits");

        tx = '{8'hD2};
        q_pid.push_back(4'h2);
        send_pkt(8, 1, 1, mk(1, 0, 0, 0, 0, 11'h0, 0));
        tx = '{8'h5A, 8'h00};
        q_pid.push_back(4'hA);
        send_pkt(9, 0, 1, mk(0, 0, 0, 1, 0, 11'h0, 0));
        wait_idle("b2b_nak_extra");

        tx = '{8'hD2};
        send_pkt(4, 0, 1, mk(0, 0, 0, 1, 0, 11'h0, 0));
        wait_idle("eop_in_pid");

        tx = '{8'hC3};
        for (int k = 0; k < 64; k++) tx.push_back(8'(k * 37 + 5));
        begin
            logic [15:0] c;
            c = crc16_field(1, 64);
            tx.push_back(c[7:0]);
            tx.push_back(c[15:8]);
        end
        q_pid.push_back(4'h3);
        push_payload(1, 64);
        send_pkt(67 * 8, 0, 1, mk(1, 0, 0, 0, 0, 11'h0, 0));
        wait_idle("data_max");

        tx.push_back(8'h5C);
        q_pid.push_back(4'h3);
        push_payload(1, 64);
        send_pkt(68 * 8, 0, 1, mk(0, 0, 0, 1, 0, 11'h0, 0));
        wait_idle("data_overflow");

        tx = '{8'hC3, 8'h11, 8'h22, 8'h33};
        q_pid.push_back(4'h3);
        q_byte.push_back(8'h11);
        send_pkt(32, 0, 0, mk(0, 0, 0, 0, 0, 11'h0, 0));
        repeat (2) tick;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {pktStart, pidValid, pid, dataByteValid, dataByte, tokenValid, tokenData,
                                 pktDone, pktOk, errPid, errCrc, errLen}, 32'h0);
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (10) tick;
        wait_idle("midreset");

        tx = '{8'hD2};
        q_pid.push_back(4'h2);
        send_pkt(8, 0, 1, mk(1, 0, 0, 0, 0, 11'h0, 0));
        wait_idle("ack_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
